mor1kx_irq_ctrl: RTL and testbench



---
 rtl/mor1kx_irq_ctrl.sv | 93 +++++++++
 tb/tb_mor1kx_irq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_irq_ctrl.sv
// Interrupt front-end for the mor1kx PIC: per-line polarity fix, synchronisation,
// level/edge capture with sticky pending, masking. Macro MOR1KX_IRQ_SYNC_EN adds a second sync flop.
module mor1kx_irq_ctrl #(
  parameter int          NUM_IRQ    = 32,
  parameter logic [31:0] EDGE_SEL   = 32'h0,
  parameter logic [31:0] ACTIVE_LOW = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] irq_clr_i,
  output logic [31:0]        irq_o,
  output logic               irq_pending_o
);

  localparam logic [NUM_IRQ-1:0] EDGE_MASK = EDGE_SEL[NUM_IRQ-1:0];
  localparam logic [NUM_IRQ-1:0] POL_MASK  = ACTIVE_LOW[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] s1_d, s1_q;
  logic [NUM_IRQ-1:0] s_s;
  logic [NUM_IRQ-1:0] h_d, h_q;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] pend_d, pend_q;
  logic [NUM_IRQ-1:0] masked_s;
  logic [31:0]        irq_d, irq_q;
  logic               pending_d, pending_q;

`ifdef MOR1KX_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] s2_d, s2_q;

  // Second synchroniser stage for inputs asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= {NUM_IRQ{1'b0}};
    end else begin
      s2_q <= s2_d;
    end
  end

  assign s2_d = s1_q;
  assign s_s  = s2_q;
`else
  assign s_s  = s1_q;
`endif

  // Next-state logic: polarity fix, edge detect, sticky pending, mask.
  always_comb begin
    s1_d     = irq_i ^ POL_MASK;
    h_d      = s_s;
    rise_s   = s_s & ~h_q;
    pend_d   = pend_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        // A rise in the same cycle as a clear wins, so no edge is lost.
        if (rise_s[i]) begin
          pend_d[i] = 1'b1;
        end else if (irq_clr_i[i]) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = pend_q[i];
        end
      end else begin
        pend_d[i] = s_s[i];
      end
    end
    masked_s  = pend_q & irq_mask_i;
    irq_d     = 32'h0;
    irq_d[NUM_IRQ-1:0] = masked_s;
    pending_d = |masked_s;
  end

  // State and output registers; reset value 0 means "not asserted" everywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= {NUM_IRQ{1'b0}};
      h_q       <= {NUM_IRQ{1'b0}};
      pend_q    <= {NUM_IRQ{1'b0}};
      irq_q     <= 32'h0;
      pending_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      h_q       <= h_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
    end
  end

  assign irq_o         = irq_q;
  assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_mor1kx_irq_ctrl.sv
// Self-checking bench for mor1kx_irq_ctrl: a 32-line and a 4-line instance compared
// against a delay-based reference model, plus directed scenario checks.
module tb_mor1kx_irq_ctrl;

`ifdef MOR1KX_IRQ_SYNC_EN
  localparam int STG = 2;
`else
  localparam int STG = 1;
`endif
  localparam int LAT = STG + 1;

  localparam logic [31:0] EDGE_W = 32'hA5A0_000C;
  localparam logic [31:0] AL_W   = 32'h3C00_0080;
  localparam logic [3:0]  EDGE_N = 4'b0101;
  localparam logic [3:0]  AL_N   = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_w, mask_w, clr_w;
  logic [31:0] irq_o_w;
  logic        pend_o_w;
  logic [3:0]  irq_n, mask_n, clr_n;
  logic [31:0] irq_o_n;
  logic        pend_o_n;

  int checks = 0;
  int failures = 0;

  // Reference model: history of asserted vectors since reset release.
  logic [31:0] hist_w[$];
  logic [31:0] hist_n[$];
  logic [31:0] pend_w = 32'h0, exp_w = 32'h0;
  logic [31:0] pend_m = 32'h0, exp_n = 32'h0;

  always #5 clk = ~clk;

  mor1kx_irq_ctrl #(.NUM_IRQ(32), .EDGE_SEL(EDGE_W), .ACTIVE_LOW(AL_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_w), .irq_mask_i(mask_w), .irq_clr_i(clr_w),
    .irq_o(irq_o_w), .irq_pending_o(pend_o_w));

  mor1kx_irq_ctrl #(.NUM_IRQ(4), .EDGE_SEL({28'h0, EDGE_N}), .ACTIVE_LOW({28'h0, AL_N})) dut4 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_n), .irq_mask_i(mask_n), .irq_clr_i(clr_n),
    .irq_o(irq_o_n), .irq_pending_o(pend_o_n));

  // Asserted vector d samples ago (0 before reset release).
  function automatic logic [31:0] back(input logic [31:0] q[$], input int d);
    int idx;
    idx = q.size() - 1 - d;
    if (idx >= 0) return q[idx];
    return 32'h0;
  endfunction

  // One clock edge: advance the reference model with the inputs sampled at that edge.
  task automatic tick();
    logic [31:0] sv, hv;
    @(posedge clk);
    if (rst_n) begin
      hist_w.push_back(irq_w ^ AL_W);
      if (hist_w.size() > 6) void'(hist_w.pop_front());
      sv = back(hist_w, STG);
      hv = back(hist_w, STG + 1);
      exp_w  = pend_w & mask_w;
      pend_w = (~EDGE_W & sv) | (EDGE_W & ((sv & ~hv) | (pend_w & ~clr_w)));

      hist_n.push_back({28'h0, irq_n ^ AL_N});
      if (hist_n.size() > 6) void'(hist_n.pop_front());
      sv = back(hist_n, STG);
      hv = back(hist_n, STG + 1);
      exp_n  = pend_m & {28'h0, mask_n};
      pend_m = ({28'h0, ~EDGE_N} & sv) |
               ({28'h0, EDGE_N} & ((sv & ~hv) | (pend_m & {28'h0, ~clr_n})));
    end else begin
      hist_w.delete();
      hist_n.delete();
      pend_w = 32'h0; exp_w = 32'h0;
      pend_m = 32'h0; exp_n = 32'h0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    irq_w = $urandom; mask_w = 32'hFFFF_FFFF; clr_w = 32'h0;
    irq_n = 4'($urandom); mask_n = 4'hF; clr_n = 4'h0;
    repeat (3) tick();
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0 || irq_o_n !== 32'h0 || pend_o_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: irq_o=%h/%h pend=%b/%b, required all 0", irq_o_w, irq_o_n, pend_o_w, pend_o_n);
    end
    irq_w = AL_W; irq_n = AL_N;
    rst_n = 1'b1;
    tick();
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0 || irq_o_n !== 32'h0 || pend_o_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge: irq_o=%h/%h pend=%b/%b, required all 0", irq_o_w, irq_o_n, pend_o_w, pend_o_n);
    end
    repeat (LAT + 1) tick();
  endtask

  task automatic test_level();
    irq_w = AL_W ^ 32'h0000_0020;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      checks++;
      if ({pend_o_w, irq_o_w} !== {|exp_w, exp_w}) begin
        failures++;
        $display("FAIL level_model: irq_o=%h pend=%b, required %h %b", irq_o_w, pend_o_w, exp_w, |exp_w);
      end
    end
    checks++;
    if (irq_o_w !== 32'h0000_0020 || pend_o_w !== 1'b1) begin
      failures++;
      $display("FAIL level_assert: irq_o=%h pend=%b, required 00000020 1", irq_o_w, pend_o_w);
    end
    irq_w = AL_W;
    repeat (LAT + 1) tick();
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0) begin
      failures++;
      $display("FAIL level_deassert: irq_o=%h pend=%b, required 0 0", irq_o_w, pend_o_w);
    end
  endtask

  task automatic test_edge();
    irq_w = AL_W ^ 32'h8;
    repeat (2) tick();
    irq_w = AL_W;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      checks++;
      if (irq_o_w !== exp_w) begin
        failures++;
        $display("FAIL edge_model: irq_o=%h, required %h", irq_o_w, exp_w);
      end
    end
    checks++;
    if (irq_o_w[3] !== 1'b1) begin
      failures++;
      $display("FAIL edge_sticky: irq_o[3]=%b, required 1", irq_o_w[3]);
    end
    clr_w = 32'h8;
    tick();
    clr_w = 32'h0;
    tick();
    checks++;
    if (irq_o_w[3] !== 1'b0) begin
      failures++;
      $display("FAIL edge_clear: irq_o[3]=%b, required 0", irq_o_w[3]);
    end
    irq_w = AL_W ^ 32'h8;
    repeat (20) tick();
    clr_w = 32'h8;
    tick();
    clr_w = 32'h0;
    repeat (4) tick();
    checks++;
    if (irq_o_w[3] !== 1'b0 || irq_o_w !== exp_w) begin
      failures++;
      $display("FAIL edge_single_set: irq_o=%h, required bit3=0 and %h", irq_o_w, exp_w);
    end
    irq_w = AL_W;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_set_beats_clear();
    irq_w = AL_W ^ 32'h8;
    clr_w = 32'h8;
    repeat (STG + 1) tick();
    clr_w = 32'h0;
    tick();
    checks++;
    if (irq_o_w[3] !== 1'b1 || irq_o_w !== exp_w) begin
      failures++;
      $display("FAIL set_beats_clear: irq_o=%h, required bit3=1 and %h", irq_o_w, exp_w);
    end
    irq_w = AL_W;
    clr_w = 32'h8;
    tick();
    clr_w = 32'h0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_active_low();
    rst_n = 1'b0;
    irq_w = AL_W;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 2) tick();
    checks++;
    if (irq_o_w !== 32'h0) begin
      failures++;
      $display("FAIL active_low_idle: irq_o=%h, required 0", irq_o_w);
    end
    irq_w = AL_W ^ 32'h80;
    repeat (LAT + 1) tick();
    checks++;
    if (irq_o_w !== 32'h0000_0080 || irq_o_w !== exp_w) begin
      failures++;
      $display("FAIL active_low_assert: irq_o=%h, required 00000080 (model %h)", irq_o_w, exp_w);
    end
    irq_w = AL_W;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_mask();
    mask_w = ~32'h4;
    irq_w = AL_W ^ 32'h4;
    repeat (LAT + 3) tick();
    irq_w = AL_W;
    tick();
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0) begin
      failures++;
      $display("FAIL mask_block: irq_o=%h pend=%b, required 0 0", irq_o_w, pend_o_w);
    end
    mask_w = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (irq_o_w !== 32'h4 || pend_o_w !== 1'b1) begin
      failures++;
      $display("FAIL mask_release: irq_o=%h pend=%b, required 00000004 1", irq_o_w, pend_o_w);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: irq_o=%h pend=%b, required 0 0", irq_o_w, pend_o_w);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 2) tick();
    checks++;
    if (irq_o_w !== 32'h0 || pend_o_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_lost_edge: irq_o=%h pend=%b, required 0 0", irq_o_w, pend_o_w);
    end
  endtask

  task automatic test_narrow();
    irq_n = AL_N ^ 4'hF;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      checks++;
      if ({pend_o_n, irq_o_n} !== {|exp_n, exp_n}) begin
        failures++;
        $display("FAIL narrow_model: irq_o=%h pend=%b, required %h %b", irq_o_n, pend_o_n, exp_n, |exp_n);
      end
    end
    checks++;
    if (irq_o_n !== 32'h0000_000F || pend_o_n !== 1'b1) begin
      failures++;
      $display("FAIL narrow_all: irq_o=%h pend=%b, required 0000000f 1", irq_o_n, pend_o_n);
    end
    irq_n = AL_N;
    clr_n = 4'hF;
    tick();
    clr_n = 4'h0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) irq_w = $urandom;
      if ($urandom_range(3) == 0) irq_n = 4'($urandom);
      if ($urandom_range(7) == 0) mask_w = $urandom;
      if ($urandom_range(7) == 0) mask_n = 4'($urandom);
      clr_w = $urandom & $urandom & $urandom;
      clr_n = 4'($urandom & $urandom);
      tick();
      checks++;
      if ({pend_o_w, irq_o_w} !== {|exp_w, exp_w}) begin
        failures++;
        $display("FAIL random_wide: cycle %0d irq_o=%h pend=%b, required %h %b", i, irq_o_w, pend_o_w, exp_w, |exp_w);
      end
      checks++;
      if ({pend_o_n, irq_o_n} !== {|exp_n, exp_n}) begin
        failures++;
        $display("FAIL random_narrow: cycle %0d irq_o=%h pend=%b, required %h %b", i, irq_o_n, pend_o_n, exp_n, |exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_set_beats_clear();
    test_active_low();
    test_mask();
    test_narrow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
